// File: rtl/layer_output_serializer.sv
// rtl/layer_output_serializer.sv - captures per-neuron activations and streams them index 0 first; define ARGMAX_EN to add the argmax tracker
module layer_output_serializer #(
  parameter int numNeurons = 32,
  parameter int dataWidth  = 16,
  parameter int idxWidth   = $clog2(numNeurons)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            layerStart,
  input  logic [numNeurons*dataWidth-1:0] neuronOutVec,
  input  logic [numNeurons-1:0]           neuronValidVec,
  output logic [dataWidth-1:0]            outData,
  output logic                            outValid,
  input  logic                            outReady,
  output logic                            outLast,
  output logic [idxWidth-1:0]             outIndex,
  output logic                            busy,
  output logic                            startDropped,
  output logic [idxWidth-1:0]             maxIndex,
  output logic                            maxValid
);

  localparam logic [idxWidth-1:0] lastIdx = idxWidth'(numNeurons - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} stateType;

  stateType              state;
  stateType              nextState;
  logic [numNeurons-1:0] mask;
  logic [dataWidth-1:0]  hold [numNeurons];
  logic [idxWidth-1:0]   cnt;
  logic [numNeurons-1:0] newCapture;
  logic                  captureDone;
  logic                  xfer;
  logic                  lastXfer;

  // A neuron is latched only the first time it reports valid during CAPTURE.
  assign newCapture  = (state == CAPTURE) ? (neuronValidVec & ~mask) : '0;
  assign captureDone = &(mask | newCapture);
  assign xfer        = (state == STREAM) && outReady;
  assign lastXfer    = xfer && (cnt == lastIdx);

  // State register; reset aborts any capture or stream immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and stream outputs; outputs read 0 whenever no word is offered.
  always_comb begin
    nextState = state;
    outValid  = 1'b0;
    outData   = '0;
    outIndex  = '0;
    outLast   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (layerStart) nextState = CAPTURE;
      end
      CAPTURE: begin
        if (captureDone) nextState = STREAM;
      end
      STREAM: begin
        outValid = 1'b1;
        outData  = hold[cnt];
        outIndex = cnt;
        outLast  = (cnt == lastIdx);
        if (lastXfer) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Capture mask and stream counter; both return to zero after the last word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (layerStart) mask <= '0;
        end
        CAPTURE: begin
          mask <= mask | newCapture;
        end
        STREAM: begin
          if (lastXfer) begin
            cnt  <= '0;
            mask <= '0;
          end else if (xfer) begin
            cnt <= cnt + idxWidth'(1);
          end
        end
        default: begin
          mask <= '0;
          cnt  <= '0;
        end
      endcase
    end
  end

  // Holding registers freeze each neuron's first valid word for the vector.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < numNeurons; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < numNeurons; i++) begin
        if (newCapture[i]) hold[i] <= neuronOutVec[i*dataWidth +: dataWidth];
      end
    end
  end

  // A start request while busy is dropped and flagged for one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      startDropped <= 1'b0;
    end else begin
      startDropped <= layerStart && (state != IDLE);
    end
  end

`ifdef ARGMAX_EN
  logic signed [dataWidth-1:0] runMax;
  logic [idxWidth-1:0]         runIdx;
  logic                        takeNew;

  // Word 0 seeds the running max; strict compare keeps the lower index on ties.
  assign takeNew = (cnt == '0) || ($signed(outData) > runMax);

  // Running signed max over accepted words; result published after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      runMax   <= '0;
      runIdx   <= '0;
      maxIndex <= '0;
      maxValid <= 1'b0;
    end else begin
      maxValid <= lastXfer;
      if (xfer && takeNew) begin
        runMax <= $signed(outData);
        runIdx <= cnt;
      end
      if (lastXfer) maxIndex <= takeNew ? cnt : runIdx;
    end
  end
`else
  assign maxIndex = '0;
  assign maxValid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_output_serializer.sv
// tb/tb_layer_output_serializer.sv - table-driven and randomized bench for layer_output_serializer
module tb_layer_output_serializer;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic           layerStart;
  logic [N*W-1:0] neuronOutVec;
  logic [N-1:0]   neuronValidVec;
  logic [W-1:0]   outData;
  logic           outValid;
  logic           outReady;
  logic           outLast;
  logic [IW-1:0]  outIndex;
  logic           busy;
  logic           startDropped;
  logic [IW-1:0]  maxIndex;
  logic           maxValid;

  layer_output_serializer #(.numNeurons(N), .dataWidth(W)) dut (
    .clk(clk), .reset(reset), .layerStart(layerStart),
    .neuronOutVec(neuronOutVec), .neuronValidVec(neuronValidVec),
    .outData(outData), .outValid(outValid), .outReady(outReady),
    .outLast(outLast), .outIndex(outIndex), .busy(busy),
    .startDropped(startDropped), .maxIndex(maxIndex), .maxValid(maxValid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][W-1:0] vals;
    logic [N-1:0][4:0]   arr;
    int                  expStart;
    int                  expMax;
    int                  mode;
    bit                  armGarbage;
    bit                  dropTest;
  } vec_t;

  vec_t tbl [5];
  int passCount  = 0;
  int totalCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalCount++;
    if (act === exp) passCount++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mkVec(input logic [N-1:0][W-1:0] vals, input logic [N-1:0][4:0] arr,
                                 input int expStart, input int expMax, input int mode,
                                 input bit armGarbage, input bit dropTest);
    vec_t v;
    v.vals = vals; v.arr = arr; v.expStart = expStart; v.expMax = expMax;
    v.mode = mode; v.armGarbage = armGarbage; v.dropTest = dropTest;
    return v;
  endfunction

  // Reference model: vector = first values, start = one cycle after latest arrival, signed argmax.
  function automatic vec_t makeRandom();
    vec_t v;
    int mx;
    int best;
    int s;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      v.vals[i] = W'($urandom());
      v.arr[i]  = 5'($urandom_range(0, 7));
      if (int'(v.arr[i]) > mx) mx = int'(v.arr[i]);
    end
    v.expStart = mx + 1;
    v.expMax = 0;
    best = $signed(v.vals[0]);
    for (int i = 1; i < N; i++) begin
      s = $signed(v.vals[i]);
      if (s > best) begin
        best = s;
        v.expMax = i;
      end
    end
    v.mode = 2;
    v.armGarbage = bit'($urandom_range(0, 1));
    v.dropTest = 1'b0;
    return v;
  endfunction

  task automatic driveCycle(input vec_t v, input int t);
    for (int i = 0; i < N; i++) begin
      if (t < int'(v.arr[i])) begin
        neuronValidVec[i] = 1'b0;
        neuronOutVec[i*W +: W] = W'($urandom());
      end else if (t == int'(v.arr[i])) begin
        neuronValidVec[i] = 1'b1;
        neuronOutVec[i*W +: W] = v.vals[i];
      end else begin
        neuronValidVec[i] = 1'b1;
        neuronOutVec[i*W +: W] = ~v.vals[i];
      end
    end
  endtask

  task automatic runVector(input vec_t v);
    logic [W-1:0]  qd [$];
    logic [IW-1:0] qi [$];
    logic          ql [$];
    int            sc;
    bit            prevStall;
    bit            rdy;
    logic [W-1:0]  prevData;
    logic [IW-1:0] prevIdx;
    check("idle_before_arm", busy, 0);
    layerStart = 1'b1;
    if (v.armGarbage) begin
      neuronValidVec = '1;
      neuronOutVec = {$urandom(), $urandom()};
    end else begin
      neuronValidVec = '0;
    end
    tick();
    layerStart = 1'b0;
    check("busy_after_arm", busy, 1);
    for (int t = 0; t <= 40; t++) begin
      if (t == v.expStart) break;
      check("no_valid_in_capture", outValid, 0);
      driveCycle(v, t);
      tick();
    end
    check("stream_start", outValid, 1);
    neuronValidVec = '1;
    for (int i = 0; i < N; i++) neuronOutVec[i*W +: W] = ~v.vals[i];
    sc = 0;
    prevStall = 1'b0;
    prevData = '0;
    prevIdx = '0;
    while (qd.size() < N && sc < 100) begin
      check("valid_held", outValid, 1);
      if (prevStall) begin
        check("stall_data", outData, prevData);
        check("stall_idx", outIndex, prevIdx);
      end
      case (v.mode)
        0:       rdy = 1'b1;
        1:       rdy = (sc % 3 == 0);
        default: rdy = bit'($urandom_range(0, 1));
      endcase
      outReady = rdy;
      layerStart = v.dropTest && (sc == 1);
      if (v.dropTest && sc == 2) check("start_dropped_pulse", startDropped, 1);
      if (v.dropTest && sc == 3) check("start_dropped_clear", startDropped, 0);
      if (outValid && rdy) begin
        qd.push_back(outData);
        qi.push_back(outIndex);
        ql.push_back(outLast);
      end
      prevStall = outValid && !rdy;
      prevData = outData;
      prevIdx = outIndex;
      tick();
      sc++;
    end
    layerStart = 1'b0;
    check("stream_in_budget", 32'(sc < 100), 1);
    if (v.mode == 0) check("throughput_cycles", sc, N);
    check("idle_after_stream", busy, 0);
    check("valid_after_stream", outValid, 0);
`ifdef ARGMAX_EN
    check("max_valid_pulse", maxValid, 1);
    check("max_index", maxIndex, v.expMax);
`else
    check("max_valid_off", maxValid, 0);
    check("max_index_off", maxIndex, 0);
`endif
    check("word_count", qd.size(), N);
    for (int i = 0; i < qd.size(); i++) begin
      check("word_data", qd[i], v.vals[i]);
      check("word_index", qi[i], i);
      check("word_last", ql[i], (i == N - 1));
    end
    tick();
    check("max_valid_one_cycle", maxValid, 0);
    check("no_recapture", busy, 0);
`ifdef ARGMAX_EN
    check("max_index_hold", maxIndex, v.expMax);
`endif
  endtask

  task automatic resetMidStream();
    layerStart = 1'b1;
    neuronValidVec = '0;
    tick();
    layerStart = 1'b0;
    for (int i = 0; i < N; i++) neuronOutVec[i*W +: W] = W'(16'h1000 + i);
    neuronValidVec = '1;
    outReady = 1'b1;
    tick();
    check("t5_stream", outValid, 1);
    tick();
    tick();
    check("t5_idx_before_reset", outIndex, 2);
    reset = 1'b1;
    #1;
    check("t5_valid_async", outValid, 0);
    check("t5_busy_async", busy, 0);
    check("t5_data_async", outData, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("t5_ignore_valids_busy", busy, 0);
      check("t5_ignore_valids_out", outValid, 0);
      tick();
    end
    neuronValidVec = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    layerStart = 1'b0;
    outReady = 1'b0;
    neuronOutVec = '0;
    neuronValidVec = '0;
    tick();
    tick();
    check("rst_outValid", outValid, 0);
    check("rst_outData", outData, 0);
    check("rst_outIndex", outIndex, 0);
    check("rst_outLast", outLast, 0);
    check("rst_busy", busy, 0);
    check("rst_startDropped", startDropped, 0);
    check("rst_maxValid", maxValid, 0);
    check("rst_maxIndex", maxIndex, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    tbl[0] = mkVec({16'h0400, 16'h0300, 16'h0200, 16'h0100}, {5'd0, 5'd0, 5'd0, 5'd0}, 1, 3, 0, 1'b0, 1'b0);
    tbl[1] = mkVec({16'h4444, 16'h3333, 16'h2222, 16'h1111}, {5'd2, 5'd6, 5'd4, 5'd9}, 10, 3, 2, 1'b0, 1'b0);
    tbl[2] = mkVec({16'h0010, 16'h0280, 16'h0280, 16'hFF00}, {5'd2, 5'd0, 5'd3, 5'd1}, 4, 1, 1, 1'b0, 1'b0);
    tbl[3] = mkVec({16'hFFFF, 16'h0000, 16'h7FFF, 16'h8000}, {5'd5, 5'd5, 5'd5, 5'd5}, 6, 1, 1, 1'b0, 1'b0);
    tbl[4] = mkVec({16'h0001, 16'h0001, 16'h5555, 16'hAAAA}, {5'd1, 5'd0, 5'd1, 5'd0}, 2, 1, 0, 1'b1, 1'b1);

    for (int k = 0; k < 5; k++) runVector(tbl[k]);
    resetMidStream();
    for (int k = 0; k < 8; k++) runVector(makeRandom());

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
